// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and imem (slave).
interface instruction_fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Single-issue instruction fetch: PC sequencing, imem handshake, stall hold and branch flush.
// Optional IFETCH_ALIGN_CHECK_EN adds a sticky misalign_err flag for unaligned branch targets.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic [31:0]              branch_target,
    instruction_fetch_unit_if.master imem,
    output logic [31:0]              instruction_out,
    output logic [31:0]              pc_out,
    output logic                     fetch_valid
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    output logic                     misalign_err
`endif
);
    localparam int unsigned     XLEN       = 32;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target_aligned;
    logic            hold_req;

    assign target_aligned = branch_target & ALIGN_MASK;

    // A presented instruction that downstream refuses must not be overwritten, so drop the request.
    assign hold_req  = fetch_valid && stall;
    assign imem.req  = (state == FETCH) && !hold_req;
    assign imem.addr = pc;

    // Fetch sequencing; a redirect overrides every state and any concurrent ack or stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            instruction_out <= '0;
            pc_out          <= '0;
            fetch_valid     <= 1'b0;
        end else if (branch_taken) begin
            pc          <= target_aligned;
            fetch_valid <= 1'b0;
            state       <= FLUSH;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (hold_req) begin
                        state <= HOLD;
                    end else if (imem.ack) begin
                        instruction_out <= imem.rdata;
                        pc_out          <= pc;
                        fetch_valid     <= 1'b1;
                        pc              <= pc + PC_STEP;
                    end else begin
                        fetch_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        fetch_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                FLUSH:   state <= FETCH;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    // Sticky record of any redirect to a non-word-aligned target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_err <= 1'b0;
        end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit against a transaction-level fetch model.
module tb_instruction_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        fetch_valid;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        misalign_err;
    logic        misalign_exp;
`endif

    instruction_fetch_unit_if imem_bus ();

    instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem           (imem_bus),
        .instruction_out(instruction_out),
        .pc_out         (pc_out),
        .fetch_valid    (fetch_valid)
`ifdef IFETCH_ALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    fetch_t      sb[$];          // delivered-but-not-yet-consumed instructions
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_pc;       // address the next accepted fetch must use
    int          since_redirect; // 1: dead cycle after reset/branch, 2: normal
    logic        held_prev;      // previous cycle refused a presented instruction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented instruction must match the oldest expected delivery.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && fetch_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_valid: fetch_valid got 1 expected 0 (pc_out=%h)", pc_out);
                end else begin
                    check("pc_out", pc_out, sb[0].pc);
                    check("instruction_out", instruction_out, sb[0].instr);
                    if (!stall) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic apply_reset();
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = '0;
        #1;
        check("rst_instruction_out", instruction_out, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        check("rst_imem_req", 32'(imem_bus.req), 32'h0);
        check("rst_imem_addr", imem_bus.addr, RESET_PC);
`ifdef IFETCH_ALIGN_CHECK_EN
        check("rst_misalign_err", 32'(misalign_err), 32'h0);
        misalign_exp = 1'b0;
`endif
        sb.delete();
        model_pc       = RESET_PC;
        since_redirect = 1;
        held_prev      = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock cycle: drive inputs, act as imem (ack with ack_pct% chance), update the model.
    task automatic drive_cycle(input logic st, input logic br, input logic [31:0] tgt,
                               input int unsigned ack_pct);
        logic req_exp;
        logic do_ack;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        #1;
        if (since_redirect == 1 || held_prev) req_exp = 1'b0;
        else                                 req_exp = !((sb.size() != 0) && st);
        check("imem_req", 32'(imem_bus.req), 32'(req_exp));
        if (imem_bus.req) check("imem_addr", imem_bus.addr, model_pc);
`ifdef IFETCH_ALIGN_CHECK_EN
        check("misalign_err", 32'(misalign_err), 32'(misalign_exp));
`endif
        do_ack = imem_bus.req && ($urandom_range(99) < ack_pct);
        imem_bus.ack   = do_ack;
        imem_bus.rdata = do_ack ? mem_word(imem_bus.addr) : $urandom();
        @(posedge clk);
        held_prev = !br && st && (sb.size() != 0);
        if (br) begin
            if (st) sb.delete();
            model_pc       = tgt & ~32'd3;
            since_redirect = 1;
`ifdef IFETCH_ALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) misalign_exp = 1'b1;
`endif
        end else begin
            if (do_ack) begin
                sb.push_back(fetch_t'{pc: model_pc, instr: mem_word(model_pc)});
                model_pc = model_pc + 32'd4;
            end
            since_redirect = 2;
        end
        #1;
        imem_bus.ack = 1'b0;
    endtask

    initial begin : stimulus
        logic [31:0] tgt;
        reset = 1'b0;
        #2;
        apply_reset();

        // Back-to-back stream from reset; first valid in the third cycle after release.
        for (int cyc = 1; cyc <= 7; cyc++) begin
            if (cyc <= 3) check("first_valid_latency", 32'(fetch_valid), 32'(cyc == 3));
            drive_cycle(1'b0, 1'b0, 32'h0, 100);
        end

        // Stall three cycles with an instruction presented, then release.
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 32'h0, 100);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 32'h0, 100);

        // Branch to 0x100 in the same cycle 0x10 is acked.
        drive_cycle(1'b0, 1'b1, 32'h10, 100);
        drive_cycle(1'b0, 1'b0, 32'h0, 100);
        drive_cycle(1'b0, 1'b1, 32'h100, 100);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 32'h0, 100);

        // Branch with a stall in the same cycle, then a misaligned target.
        drive_cycle(1'b1, 1'b1, 32'h200, 100);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 32'h0, 100);
        drive_cycle(1'b0, 1'b1, 32'h102, 100);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 32'h0, 100);

        // PC wrap at the top of the address space.
        drive_cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 100);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 32'h0, 100);

        // Slow memory, then reset while a request is outstanding.
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 32'h0, 0);
        drive_cycle(1'b0, 1'b0, 32'h0, 100);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 32'h0, 0);
        apply_reset();
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, 32'h0, 100);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(3))
                0:       tgt = $urandom();
                1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(15));
                default: tgt = 32'($urandom_range(255)) << 2;
            endcase
            if ($urandom_range(299) == 0) apply_reset();
            drive_cycle(($urandom_range(3) == 0), ($urandom_range(15) == 0), tgt, 60);
        end

        // Drain: every delivered instruction must have been presented and consumed.
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 32'h0, 0);
        check("drain_outstanding", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
